// File: rtl/reg_file.sv
// General-purpose register file: two asynchronous read ports, one synchronous write port, r0 hard-wired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SP_IDX  = 29,
    parameter int SP_INIT = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              reg_write_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DATA_W-1:0] rs_data_s;
    logic [DATA_W-1:0] rt_data_s;
    logic              wr_en_s;
    logic              rs_fwd_s;
    logic              rt_fwd_s;

    assign wr_en_s = reg_write_i && (rd_addr_i != ZERO_ADDR);

`ifdef REG_BYPASS_EN
    // Forwarding is suppressed during reset so the reset image stays visible.
    assign rs_fwd_s = rst_i && wr_en_s && (rd_addr_i == rs_addr_i);
    assign rt_fwd_s = rst_i && wr_en_s && (rd_addr_i == rt_addr_i);
`else
    assign rs_fwd_s = 1'b0;
    assign rt_fwd_s = 1'b0;
`endif

    // Register storage: async reset image, then enabled writes; entry 0 is never written
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == SP_IDX) begin
                    regs_r[i] <= DATA_W'(SP_INIT);
                end else begin
                    regs_r[i] <= ZERO_DATA;
                end
            end
        end else if (wr_en_s) begin
            regs_r[rd_addr_i] <= rd_data_i;
        end
    end

    // Read port A: zero register, optional forward, else stored value
    always_comb begin
        rs_data_s = ZERO_DATA;
        if (rs_addr_i == ZERO_ADDR) begin
            rs_data_s = ZERO_DATA;
        end else if (rs_fwd_s) begin
            rs_data_s = rd_data_i;
        end else begin
            rs_data_s = regs_r[rs_addr_i];
        end
    end

    // Read port B: zero register, optional forward, else stored value
    always_comb begin
        rt_data_s = ZERO_DATA;
        if (rt_addr_i == ZERO_ADDR) begin
            rt_data_s = ZERO_DATA;
        end else if (rt_fwd_s) begin
            rt_data_s = rd_data_i;
        end else begin
            rt_data_s = regs_r[rt_addr_i];
        end
    end

    assign rs_data_o = rs_data_s;
    assign rt_data_o = rt_data_s;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps, expected read values queued at drive time and popped at sampling.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic [31:0] sb [$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    reg_file dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rs_addr_i   (rs_addr),
        .rt_addr_i   (rt_addr),
        .rd_addr_i   (rd_addr),
        .rd_data_i   (rd_data),
        .reg_write_i (reg_write),
        .rs_data_o   (rs_data),
        .rt_data_o   (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[29] = 32'd128;
    endtask

    task automatic drive_reads(input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] ea, input logic [31:0] eb);
        rs_addr = a;
        rt_addr = b;
        sb.push_back(ea);
        sb.push_back(eb);
    endtask

    task automatic compare_reads(input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        #1;
        ea = sb.pop_front();
        eb = sb.pop_front();
        checks++;
        assert (rs_data === ea) else begin
            errors++;
            $error("FAIL %s rs[%0d] observed=%h expected=%h", tag, rs_addr, rs_data, ea);
        end
        checks++;
        assert (rt_data === eb) else begin
            errors++;
            $error("FAIL %s rt[%0d] observed=%h expected=%h", tag, rt_addr, rt_data, eb);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = a;
        rd_data   = d;
        @(posedge clk);
        if (a != 5'd0) model[a] = d;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        reg_write = 1'b0;
        rs_addr   = 5'd0;
        rt_addr   = 5'd0;
        rd_addr   = 5'd0;
        rd_data   = 32'h0;
        reset_model();
        #1 rst = 1'b0;

        // T1: reset image on both ports, then a write attempt while in reset
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            drive_reads(5'(a), 5'(31 - a), (a == 29) ? 32'd128 : 32'h0,
                        (31 - a == 29) ? 32'd128 : 32'h0);
            compare_reads("t1_reset_sweep");
        end
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd5;
        rd_data   = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        drive_reads(5'd5, 5'd29, 32'h0, 32'd128);
        compare_reads("t1_write_in_reset");

        // T2: release reset, write r1 then r31
        rst = 1'b1;
        do_write(5'd1, 32'h0000_0007);
        reg_write = 1'b1;
        rd_addr   = 5'd31;
        rd_data   = 32'hFFFF_FFFF;
        drive_reads(5'd1, 5'd2, 32'h0000_0007, 32'h0);
        compare_reads("t2_other_unchanged");
        @(posedge clk);
        model[31] = 32'hFFFF_FFFF;
        @(negedge clk);
        reg_write = 1'b0;
        drive_reads(5'd1, 5'd31, 32'h0000_0007, 32'hFFFF_FFFF);
        compare_reads("t2_readback");

        // T3: writes to r0 are dropped
        reg_write = 1'b1;
        rd_addr   = 5'd0;
        rd_data   = 32'h1234_5678;
        drive_reads(5'd0, 5'd0, 32'h0, 32'h0);
        compare_reads("t3_r0_write_cycle");
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        drive_reads(5'd0, 5'd0, 32'h0, 32'h0);
        compare_reads("t3_r0_after");

        // T4: enable gating, then SP overwrite
        do_write(5'd3, 32'h0000_0033);
        reg_write = 1'b0;
        rd_addr   = 5'd3;
        rd_data   = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive_reads(5'd3, 5'd29, 32'h0000_0033, 32'd128);
        compare_reads("t4_gated");
        do_write(5'd29, 32'h0000_0040);
        drive_reads(5'd29, 5'd3, 32'h0000_0040, 32'h0000_0033);
        compare_reads("t4_sp_write");

        // T5: same-address read/write hazard
        do_write(5'd2, 32'h0000_0011);
        reg_write = 1'b1;
        rd_addr   = 5'd2;
        rd_data   = 32'h0000_0022;
`ifdef REG_BYPASS_EN
        drive_reads(5'd2, 5'd2, 32'h0000_0022, 32'h0000_0022);
`else
        drive_reads(5'd2, 5'd2, 32'h0000_0011, 32'h0000_0011);
`endif
        compare_reads("t5_before_edge");
        @(posedge clk);
        drive_reads(5'd2, 5'd2, 32'h0000_0022, 32'h0000_0022);
        compare_reads("t5_after_edge");
        @(negedge clk);
        reg_write = 1'b0;

        // T6: fill, async reset between edges, write lost during reset
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
        drive_reads(5'd17, 5'd31, 32'd17, 32'd31);
        compare_reads("t6_filled");
        @(negedge clk);
        #2 rst = 1'b0;
        reset_model();
        drive_reads(5'd17, 5'd29, 32'h0, 32'd128);
        compare_reads("t6_async_clear");
        reg_write = 1'b1;
        rd_addr   = 5'd7;
        rd_data   = 32'h0000_0077;
        drive_reads(5'd7, 5'd31, 32'h0, 32'h0);
        compare_reads("t6_no_fwd_in_reset");
        @(posedge clk);
        @(negedge clk);
        reg_write = 1'b0;
        drive_reads(5'd7, 5'd31, 32'h0, 32'h0);
        compare_reads("t6_write_lost");
        #2 rst = 1'b1;
        drive_reads(5'd7, 5'd29, 32'h0, 32'd128);
        compare_reads("t6_after_release");
        do_write(5'd7, 32'h0000_0077);
        drive_reads(5'd7, 5'd1, 32'h0000_0077, model[1]);
        compare_reads("t6_first_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
